// File: rtl/sa_autosa_pdp_rdma_mport_ig_if.sv
// rtl/sa_autosa_pdp_rdma_mport_ig_if.sv - read-request and context-queue handshake bundle
// Purpose: groups the per-port read-request handshake and the context-queue handshake.
// Signals:
//   rd_req_valid [NUM_PORTS]  request valid per port (one-hot or zero)
//   rd_req_ready [NUM_PORTS]  request ready per port
//   rd_req_pd    [ADDR_W+15]  {size = atoms-1 (15b), byte address}
//   cq_pvld / cq_prdy         context entry handshake
//   cq_pd        [6]          {last_cube, last_line, atoms_m1[3:0]}
// master = ingress side, slave = memory clients / egress side.
interface sa_autosa_pdp_rdma_mport_ig_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 64
);
  logic [NUM_PORTS-1:0] rd_req_valid;
  logic [NUM_PORTS-1:0] rd_req_ready;
  logic [ADDR_W+14:0]   rd_req_pd;
  logic                 cq_pvld;
  logic                 cq_prdy;
  logic [5:0]           cq_pd;

  modport master (
    output rd_req_valid, rd_req_pd, cq_pvld, cq_pd,
    input  rd_req_ready, cq_prdy
  );

  modport slave (
    input  rd_req_valid, rd_req_pd, cq_pvld, cq_pd,
    output rd_req_ready, cq_prdy
  );
endinterface

// File: rtl/sa_autosa_pdp_rdma_mport_ig.sv
// rtl/sa_autosa_pdp_rdma_mport_ig.sv - multi-port PDP RDMA ingress with context queue
// Purpose: walks the input cube (surfaces -> lines -> bursts), issues read requests on
//   the port chosen by cfg_ram_type and records one context entry per accepted request.
// Ports:
//   autosa_core_clk, autosa_core_rst  clock, synchronous active-high reset
//   op_en, cfg_*                      start pulse and job configuration (latched at start)
//   io (master modport)               read-request and context-queue handshakes
//   busy, done, perf_stall            job status and stall counter
module sa_autosa_pdp_rdma_mport_ig #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 64,
  parameter int ATOM_BYTES = 32,
  parameter int MAX_BURST  = 8,
  parameter int CQ_DEPTH   = 16,
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 autosa_core_clk,
  input  logic                 autosa_core_rst,
  input  logic                 op_en,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [31:0]          cfg_line_stride,
  input  logic [31:0]          cfg_surf_stride,
  input  logic [12:0]          cfg_line_atoms_m1,
  input  logic [12:0]          cfg_height_m1,
  input  logic [12:0]          cfg_surf_m1,
  input  logic [PW-1:0]        cfg_ram_type,
  sa_autosa_pdp_rdma_mport_ig_if.master io,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          perf_stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int AW = $clog2(CQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [12:0]       MB13        = 13'(MAX_BURST);
  localparam logic [3:0]        MB_M1       = 4'(MAX_BURST - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(MAX_BURST * ATOM_BYTES);
  localparam logic [CW-1:0]     CQ_FULL     = CW'(CQ_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] line_stride_q, surf_stride_q;
  logic [12:0]       line_m1_q, height_m1_q, surf_m1_q;
  logic [PW-1:0]     sel_q;

  // Running accumulators replace s*surf_stride + h*line_stride + b*burst_bytes.
  logic [ADDR_W-1:0] surf_addr, line_addr, req_addr;
  logic [12:0]       rem_m1;   // atoms left in the current line, minus 1
  logic [12:0]       h_cnt, s_cnt;

  logic [3:0]        burst_m1;
  logic              last_burst, last_line_of_surf, last_surf, last_cube;
  logic              req_vld, ready_sel, hs;
  logic [ADDR_W-1:0] next_line_addr, next_surf_addr;

  logic [5:0]        cq_mem [CQ_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cq_count;
  logic              cq_pop;

  assign last_burst        = rem_m1 < MB13;
  assign burst_m1          = last_burst ? rem_m1[3:0] : MB_M1;
  assign last_line_of_surf = h_cnt == height_m1_q;
  assign last_surf         = s_cnt == surf_m1_q;
  assign last_cube         = last_burst && last_line_of_surf && last_surf;
  assign next_line_addr    = line_addr + line_stride_q;
  assign next_surf_addr    = surf_addr + surf_stride_q;

  // Valid depends only on state and queue occupancy; occupancy can only rise through
  // a handshake, so a presented request cannot be withdrawn.
  assign req_vld = (state == REQ) && (cq_count != CQ_FULL);

  always_comb begin
    ready_sel       = 1'b0;
    io.rd_req_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == sel_q) begin
        ready_sel          = io.rd_req_ready[i];
        io.rd_req_valid[i] = req_vld;
      end
    end
  end

  assign hs           = req_vld && ready_sel;
  assign io.rd_req_pd = {11'd0, burst_m1, req_addr};
  assign busy         = state == REQ;
  assign done         = state == DONE;

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state         <= IDLE;
      base_q        <= '0;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      line_m1_q     <= '0;
      height_m1_q   <= '0;
      surf_m1_q     <= '0;
      sel_q         <= '0;
      surf_addr     <= '0;
      line_addr     <= '0;
      req_addr      <= '0;
      rem_m1        <= '0;
      h_cnt         <= '0;
      s_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_en) begin
            state         <= REQ;
            base_q        <= cfg_base_addr;
            line_stride_q <= ADDR_W'(cfg_line_stride);
            surf_stride_q <= ADDR_W'(cfg_surf_stride);
            line_m1_q     <= cfg_line_atoms_m1;
            height_m1_q   <= cfg_height_m1;
            surf_m1_q     <= cfg_surf_m1;
            sel_q         <= cfg_ram_type;
            surf_addr     <= cfg_base_addr;
            line_addr     <= cfg_base_addr;
            req_addr      <= cfg_base_addr;
            rem_m1        <= cfg_line_atoms_m1;
            h_cnt         <= '0;
            s_cnt         <= '0;
          end
        end
        REQ: begin
          if (hs) begin
            if (!last_burst) begin
              rem_m1   <= rem_m1 - MB13;
              req_addr <= req_addr + BURST_BYTES;
            end else if (!last_line_of_surf) begin
              h_cnt     <= h_cnt + 13'd1;
              rem_m1    <= line_m1_q;
              line_addr <= next_line_addr;
              req_addr  <= next_line_addr;
            end else if (!last_surf) begin
              s_cnt     <= s_cnt + 13'd1;
              h_cnt     <= '0;
              rem_m1    <= line_m1_q;
              surf_addr <= next_surf_addr;
              line_addr <= next_surf_addr;
              req_addr  <= next_surf_addr;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      perf_stall <= '0;
    end else if (state == IDLE && op_en) begin
      perf_stall <= '0;
    end else if (req_vld && !ready_sel && perf_stall != 32'hFFFF_FFFF) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end

  // Context queue: entries are read straight from registered storage, so a push is
  // visible the next cycle and a pop frees a slot only from the next cycle on.
  assign io.cq_pvld = cq_count != '0;
  assign io.cq_pd   = io.cq_pvld ? cq_mem[rd_ptr] : 6'd0;
  assign cq_pop     = io.cq_pvld && io.cq_prdy;

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cq_count <= '0;
    end else begin
      if (hs) begin
        cq_mem[wr_ptr] <= {last_cube, last_burst, burst_m1};
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (cq_pop) rd_ptr <= rd_ptr + AW'(1);
      if (hs && !cq_pop)      cq_count <= cq_count + CW'(1);
      else if (!hs && cq_pop) cq_count <= cq_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_sa_autosa_pdp_rdma_mport_ig.sv
// tb/tb_sa_autosa_pdp_rdma_mport_ig.sv - scoreboard bench for sa_autosa_pdp_rdma_mport_ig
module tb_sa_autosa_pdp_rdma_mport_ig;
  localparam int NP = 2, AW = 64, AB = 32, MB = 8, CQD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_en = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [31:0]   cfg_line_stride = '0, cfg_surf_stride = '0;
  logic [12:0]   cfg_line_atoms_m1 = '0, cfg_height_m1 = '0, cfg_surf_m1 = '0;
  logic [0:0]    cfg_ram_type = '0;
  logic          busy, done;
  logic [31:0]   perf_stall;

  sa_autosa_pdp_rdma_mport_ig_if #(.NUM_PORTS(NP), .ADDR_W(AW)) ifc ();

  sa_autosa_pdp_rdma_mport_ig #(
    .NUM_PORTS(NP), .ADDR_W(AW), .ATOM_BYTES(AB), .MAX_BURST(MB), .CQ_DEPTH(CQD)
  ) dut (
    .autosa_core_clk(clk), .autosa_core_rst(rst), .op_en(op_en),
    .cfg_base_addr(cfg_base_addr), .cfg_line_stride(cfg_line_stride),
    .cfg_surf_stride(cfg_surf_stride), .cfg_line_atoms_m1(cfg_line_atoms_m1),
    .cfg_height_m1(cfg_height_m1), .cfg_surf_m1(cfg_surf_m1),
    .cfg_ram_type(cfg_ram_type), .io(ifc), .busy(busy), .done(done),
    .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [78:0] req_q[$];
  logic [5:0]  cq_q[$];
  int hs_cnt = 0, done_cnt = 0;
  int rdy_mode = 0, prdy_mode = 0;  // 0: always 1, 1: random, 2: driven by the test
  logic [0:0] cur_sel = '0;
  logic [1:0] one = 2'b01;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference model: nested loops over the cube with plain multiplication.
  task automatic build(input logic [AW-1:0] base, input logic [31:0] ls, input logic [31:0] ss,
                       input int la, input int hh, input int sn);
    for (int s = 0; s <= sn; s++)
      for (int h = 0; h <= hh; h++) begin
        int rem = la + 1;
        int b = 0;
        while (rem > 0) begin
          int n = (rem < MB) ? rem : MB;
          logic [AW-1:0] a;
          logic ll, lc;
          a  = base + 64'(s) * 64'(ss) + 64'(h) * 64'(ls) + 64'(b) * 64'(MB * AB);
          ll = rem <= MB;
          lc = ll && h == hh && s == sn;
          req_q.push_back({15'(n - 1), a});
          cq_q.push_back({lc, ll, 4'(n - 1)});
          rem -= n;
          b++;
        end
      end
  endtask

  initial begin
    ifc.rd_req_ready = '0;
    ifc.cq_prdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) ifc.rd_req_ready = '1;
      else if (rdy_mode == 1) ifc.rd_req_ready = 2'($urandom);
      if (prdy_mode == 0) ifc.cq_prdy = 1'b1;
      else if (prdy_mode == 1) ifc.cq_prdy = 1'($urandom);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.rd_req_valid != '0) chk("valid_onehot", ifc.rd_req_valid, one << cur_sel);
      if (ifc.rd_req_valid[cur_sel] && ifc.rd_req_ready[cur_sel]) begin
        hs_cnt++;
        if (req_q.size() == 0) fail_now("req_unexpected");
        else chk("req_pd", ifc.rd_req_pd, req_q.pop_front());
      end
      if (ifc.cq_pvld && ifc.cq_prdy) begin
        if (cq_q.size() == 0) fail_now("cq_unexpected");
        else chk("cq_pd", ifc.cq_pd, cq_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, ifc.rd_req_valid, 0);
    chk({tag, "_pd"}, ifc.rd_req_pd, 0);
    chk({tag, "_cq_pvld"}, ifc.cq_pvld, 0);
    chk({tag, "_cq_pd"}, ifc.cq_pd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_perf"}, perf_stall, 0);
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [31:0] ls, input logic [31:0] ss,
                           input int la, input int hh, input int sn, input logic [0:0] sel);
    @(posedge clk);
    #1;
    cfg_base_addr = base; cfg_line_stride = ls; cfg_surf_stride = ss;
    cfg_line_atoms_m1 = 13'(la); cfg_height_m1 = 13'(hh); cfg_surf_m1 = 13'(sn);
    cfg_ram_type = sel; cur_sel = sel;
    hs_cnt = 0; done_cnt = 0;
    build(base, ls, ss, la, hh, sn);
    op_en = 1'b1;
    @(posedge clk);
    #1;
    op_en = 1'b0;
    // Scramble the inputs: the DUT must work from its latched copy.
    cfg_base_addr = {$urandom, $urandom}; cfg_line_stride = $urandom;
    cfg_surf_stride = $urandom; cfg_line_atoms_m1 = 13'($urandom);
    cfg_ram_type = ~sel;
  endtask

  task automatic finish_job(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (done_cnt == 0) fail_now({tag, "_done_timeout"});
    prdy_mode = 0;
    t = 0;
    while (cq_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_req_left"}, req_q.size(), 0);
    chk({tag, "_cq_left"}, cq_q.size(), 0);
    chk({tag, "_cq_empty"}, ifc.cq_pvld, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [78:0] pd0;
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // T1 + T4: first request stalled for 10 cycles, then three bursts of a 20-atom line.
    rdy_mode = 2; prdy_mode = 0; ifc.rd_req_ready = '0;
    start_job(64'h1000, 32'h0, 32'h0, 19, 0, 0, 1'b0);
    pd0 = ifc.rd_req_pd;
    chk("t1_first_pd", pd0, {15'd7, 64'h1000});
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", ifc.rd_req_valid, 2'b01);
      chk("t4_hold_pd", ifc.rd_req_pd, pd0);
      @(posedge clk);
      #1;
    end
    ifc.rd_req_ready = '1; rdy_mode = 0;
    finish_job("t1");
    chk("t4_perf_stall", perf_stall, 10);

    // T2: port 1 selected, both ready lines random.
    rdy_mode = 1; prdy_mode = 1;
    start_job(64'h8000, 32'h400, 32'h2000, 12, 1, 1, 1'b1);
    finish_job("t2");

    // T3: queue fills to depth, then exactly one slot is released.
    rdy_mode = 0; prdy_mode = 2; ifc.cq_prdy = 1'b0;
    start_job(64'h4_0000, 32'h0, 32'h0, 79, 0, 0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("t3_accepted_full", hs_cnt, CQD);
    chk("t3_valid_low", ifc.rd_req_valid, 0);
    ifc.cq_prdy = 1'b1;
    @(posedge clk);
    #1;
    ifc.cq_prdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_accepted_after_pop", hs_cnt, CQD + 1);
    chk("t3_valid_low2", ifc.rd_req_valid, 0);
    prdy_mode = 1;
    finish_job("t3");

    // T5: two surfaces x two lines of four atoms.
    rdy_mode = 1; prdy_mode = 1;
    start_job(64'h0, 32'h200, 32'h1000, 3, 1, 1, 1'b0);
    finish_job("t5");

    // op_en during a running job is ignored.
    start_job(64'h2_0000, 32'h300, 32'h5000, 30, 2, 1, 1'b1);
    cfg_base_addr = 64'h9999_0000; cfg_line_atoms_m1 = 13'd5; cfg_ram_type = 1'b0;
    op_en = 1'b1;
    @(posedge clk);
    #1;
    op_en = 1'b0;
    finish_job("op_en_ignored");

    // Randomised jobs, including address wrap through a random 64-bit base.
    for (int j = 0; j < 6; j++) begin
      rdy_mode = 1; prdy_mode = 1;
      start_job({$urandom, $urandom} & ~64'(AB - 1), $urandom, $urandom,
                int'($urandom_range(0, 20)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom));
      finish_job("rand");
    end

    // T6: reset after two accepted requests.
    rdy_mode = 0; prdy_mode = 2; ifc.cq_prdy = 1'b0;
    start_job(64'h0, 32'h200, 32'h1000, 3, 1, 1, 1'b0);
    t = 0;
    while (hs_cnt < 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (hs_cnt < 2) fail_now("t6_hs_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("t6");
    rst = 1'b0;
    req_q.delete();
    cq_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_req", ifc.rd_req_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
